// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types used by the cache hierarchy.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_chunk;
  typedef logic [1:0]   lc3b_mem_wmask;
endpackage

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between I- and D-cache; L2 strobe one cycle after grant.
// Requesters hold their request until resp; no preemption, losers wait in place until the next IDLE cycle.
module l1_l2_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,

  input  lc3b_word      i_mem_address,
  input  logic          i_mem_read,
  output lc3b_chunk     i_mem_rdata,
  output logic          i_mem_resp,

  input  lc3b_word      d_mem_address,
  input  lc3b_chunk     d_mem_wdata,
  input  logic          d_mem_read,
  input  logic          d_mem_write,
  input  lc3b_mem_wmask d_mem_byte_enable,
  output lc3b_chunk     d_mem_rdata,
  output logic          d_mem_resp,

  output lc3b_word      l2_mem_address,
  output lc3b_chunk     l2_mem_wdata,
  output lc3b_mem_wmask l2_mem_byte_enable,
  output logic          l2_mem_read,
  output logic          l2_mem_write,
  input  lc3b_chunk     l2_mem_rdata,
  input  logic          l2_mem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  lc3b_word      addr_q, addr_d;
  lc3b_chunk     wdata_q, wdata_d;
  lc3b_mem_wmask be_q, be_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;

  logic i_req, d_req;
  logic grant_i, grant_d;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // With both pending, the side that did not win last time gets the port.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && d_req) begin
        grant_d = (last_grant_q == GRANT_I);
        grant_i = ~grant_d;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rd_d         = rd_q;
    wr_d         = wr_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = i_mem_address;
          wdata_d      = '0;
          be_d         = 2'b11;
          rd_d         = 1'b1;
          wr_d         = 1'b0;
        end else if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = d_mem_address;
          wdata_d      = d_mem_wdata;
          be_d         = d_mem_byte_enable;
          // A combined read+write from the D-cache goes out as a write.
          rd_d         = d_mem_read & ~d_mem_write;
          wr_d         = d_mem_write;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_mem_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  assign l2_mem_address     = addr_q;
  assign l2_mem_wdata       = wdata_q;
  assign l2_mem_byte_enable = be_q;
  assign l2_mem_read        = rd_q & (state_q != IDLE);
  assign l2_mem_write       = wr_q & (state_q != IDLE);

  assign i_mem_resp  = l2_mem_resp & (state_q == SERVE_I);
  assign d_mem_resp  = l2_mem_resp & (state_q == SERVE_D);
  assign i_mem_rdata = l2_mem_rdata;
  assign d_mem_rdata = l2_mem_rdata;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: each task drives one scenario and checks hand-computed values.
module tb_l1_l2_arbiter;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  lc3b_word      i_mem_address;
  logic          i_mem_read;
  lc3b_chunk     i_mem_rdata;
  logic          i_mem_resp;
  lc3b_word      d_mem_address;
  lc3b_chunk     d_mem_wdata;
  logic          d_mem_read;
  logic          d_mem_write;
  lc3b_mem_wmask d_mem_byte_enable;
  lc3b_chunk     d_mem_rdata;
  logic          d_mem_resp;
  lc3b_word      l2_mem_address;
  lc3b_chunk     l2_mem_wdata;
  lc3b_mem_wmask l2_mem_byte_enable;
  logic          l2_mem_read;
  logic          l2_mem_write;
  lc3b_chunk     l2_mem_rdata;
  logic          l2_mem_resp;

  int tests_run = 0;
  int tests_failed = 0;

  l1_l2_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .i_mem_address      (i_mem_address),
    .i_mem_read         (i_mem_read),
    .i_mem_rdata        (i_mem_rdata),
    .i_mem_resp         (i_mem_resp),
    .d_mem_address      (d_mem_address),
    .d_mem_wdata        (d_mem_wdata),
    .d_mem_read         (d_mem_read),
    .d_mem_write        (d_mem_write),
    .d_mem_byte_enable  (d_mem_byte_enable),
    .d_mem_rdata        (d_mem_rdata),
    .d_mem_resp         (d_mem_resp),
    .l2_mem_address     (l2_mem_address),
    .l2_mem_wdata       (l2_mem_wdata),
    .l2_mem_byte_enable (l2_mem_byte_enable),
    .l2_mem_read        (l2_mem_read),
    .l2_mem_write       (l2_mem_write),
    .l2_mem_rdata       (l2_mem_rdata),
    .l2_mem_resp        (l2_mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_mem_address     = '0;
    i_mem_read        = 1'b0;
    d_mem_address     = '0;
    d_mem_wdata       = '0;
    d_mem_read        = 1'b0;
    d_mem_write       = 1'b0;
    d_mem_byte_enable = '0;
    l2_mem_rdata      = '0;
    l2_mem_resp       = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (l2_mem_read !== 1'b0 || l2_mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: got rd=%b wr=%b exp rd=0 wr=0", l2_mem_read, l2_mem_write);
    end
    tests_run++;
    if (l2_mem_address !== 16'h0000 || l2_mem_wdata !== 128'h0 || l2_mem_byte_enable !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_capture: got addr=%h be=%b wdata=%h exp zeros", l2_mem_address, l2_mem_byte_enable, l2_mem_wdata);
    end
    tests_run++;
    if (i_mem_resp !== 1'b0 || d_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_resp: got i=%b d=%b exp 0 0", i_mem_resp, d_mem_resp);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_i_read();
    lc3b_chunk d1;
    d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    i_mem_address = 16'h1230;
    i_mem_read    = 1'b1;
    #1;
    tests_run++;
    if (l2_mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL iread_pre_grant: got rd=%b exp 0", l2_mem_read);
    end
    tick();
    tests_run++;
    if (l2_mem_read !== 1'b1 || l2_mem_write !== 1'b0 || l2_mem_address !== 16'h1230) begin
      tests_failed++;
      $display("FAIL iread_strobe: got rd=%b wr=%b addr=%h exp 1 0 1230", l2_mem_read, l2_mem_write, l2_mem_address);
    end
    tests_run++;
    if (l2_mem_byte_enable !== 2'b11 || l2_mem_wdata !== 128'h0) begin
      tests_failed++;
      $display("FAIL iread_fill: got be=%b wdata=%h exp 11 0", l2_mem_byte_enable, l2_mem_wdata);
    end
    tests_run++;
    if (i_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL iread_early_resp: got %b exp 0", i_mem_resp);
    end
    l2_mem_rdata = d1;
    l2_mem_resp  = 1'b1;
    #1;
    tests_run++;
    if (i_mem_resp !== 1'b1 || d_mem_resp !== 1'b0 || i_mem_rdata !== d1) begin
      tests_failed++;
      $display("FAIL iread_resp: got i=%b d=%b data=%h exp 1 0 %h", i_mem_resp, d_mem_resp, i_mem_rdata, d1);
    end
    tick();
    i_mem_read  = 1'b0;
    l2_mem_resp = 1'b0;
    #1;
    tests_run++;
    if (l2_mem_read !== 1'b0 || i_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL iread_done: got rd=%b iresp=%b exp 0 0", l2_mem_read, i_mem_resp);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    i_mem_address = 16'h0100;
    i_mem_read    = 1'b1;
    d_mem_address = 16'h0200;
    d_mem_read    = 1'b1;
    tick();
    tests_run++;
    if (l2_mem_read !== 1'b1 || l2_mem_address !== 16'h0200) begin
      tests_failed++;
      $display("FAIL simul_first_d: got rd=%b addr=%h exp 1 0200", l2_mem_read, l2_mem_address);
    end
    l2_mem_rdata = 128'hD0D0;
    l2_mem_resp  = 1'b1;
    #1;
    tests_run++;
    if (d_mem_resp !== 1'b1 || i_mem_resp !== 1'b0 || d_mem_rdata !== 128'hD0D0) begin
      tests_failed++;
      $display("FAIL simul_d_resp: got d=%b i=%b data=%h exp 1 0 d0d0", d_mem_resp, i_mem_resp, d_mem_rdata);
    end
    tick();
    d_mem_read  = 1'b0;
    l2_mem_resp = 1'b0;
    #1;
    tests_run++;
    if (l2_mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_idle_gap: got rd=%b exp 0", l2_mem_read);
    end
    tick();
    tests_run++;
    if (l2_mem_read !== 1'b1 || l2_mem_address !== 16'h0100 || l2_mem_byte_enable !== 2'b11) begin
      tests_failed++;
      $display("FAIL simul_second_i: got rd=%b addr=%h be=%b exp 1 0100 11", l2_mem_read, l2_mem_address, l2_mem_byte_enable);
    end
    l2_mem_resp = 1'b1;
    #1;
    tests_run++;
    if (i_mem_resp !== 1'b1 || d_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_i_resp: got i=%b d=%b exp 1 0", i_mem_resp, d_mem_resp);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_d_write();
    lc3b_chunk pat;
    pat = {16{8'hA5}};
    d_mem_address     = 16'h4440;
    d_mem_wdata       = pat;
    d_mem_byte_enable = 2'b01;
    d_mem_write       = 1'b1;
    tick();
    tests_run++;
    if (l2_mem_write !== 1'b1 || l2_mem_read !== 1'b0 || l2_mem_address !== 16'h4440) begin
      tests_failed++;
      $display("FAIL dwrite_strobe: got wr=%b rd=%b addr=%h exp 1 0 4440", l2_mem_write, l2_mem_read, l2_mem_address);
    end
    tests_run++;
    if (l2_mem_wdata !== pat || l2_mem_byte_enable !== 2'b01) begin
      tests_failed++;
      $display("FAIL dwrite_data: got wdata=%h be=%b exp %h 01", l2_mem_wdata, l2_mem_byte_enable, pat);
    end
    tick();
    tick();
    tests_run++;
    if (l2_mem_write !== 1'b1 || l2_mem_read !== 1'b0 || d_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL dwrite_hold: got wr=%b rd=%b dresp=%b exp 1 0 0", l2_mem_write, l2_mem_read, d_mem_resp);
    end
    l2_mem_resp = 1'b1;
    #1;
    tests_run++;
    if (d_mem_resp !== 1'b1 || i_mem_resp !== 1'b0 || l2_mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL dwrite_resp: got d=%b i=%b rd=%b exp 1 0 0", d_mem_resp, i_mem_resp, l2_mem_read);
    end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (l2_mem_write !== 1'b0 || d_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL dwrite_done: got wr=%b dresp=%b exp 0 0", l2_mem_write, d_mem_resp);
    end
    tick();
  endtask

  // Last grant was D, so a tie must go to I; D's request arriving meanwhile must not preempt.
  task automatic test_rr_no_preempt();
    i_mem_address = 16'h0AA0;
    i_mem_read    = 1'b1;
    d_mem_address = 16'h0DD0;
    d_mem_read    = 1'b1;
    tick();
    tests_run++;
    if (l2_mem_address !== 16'h0AA0 || l2_mem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rr_i_wins: got addr=%h rd=%b exp 0aa0 1", l2_mem_address, l2_mem_read);
    end
    d_mem_address = 16'h0DE0;
    tick();
    tick();
    tests_run++;
    if (l2_mem_address !== 16'h0AA0 || d_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_no_preempt: got addr=%h dresp=%b exp 0aa0 0", l2_mem_address, d_mem_resp);
    end
    l2_mem_resp = 1'b1;
    #1;
    tests_run++;
    if (i_mem_resp !== 1'b1 || d_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_i_resp: got i=%b d=%b exp 1 0", i_mem_resp, d_mem_resp);
    end
    tick();
    i_mem_read  = 1'b0;
    l2_mem_resp = 1'b0;
    tick();
    tests_run++;
    if (l2_mem_address !== 16'h0DE0 || l2_mem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rr_d_next: got addr=%h rd=%b exp 0de0 1", l2_mem_address, l2_mem_read);
    end
    l2_mem_resp = 1'b1;
    #1;
    tests_run++;
    if (d_mem_resp !== 1'b1 || i_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_d_resp: got d=%b i=%b exp 1 0", d_mem_resp, i_mem_resp);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_read_write_both();
    d_mem_address     = 16'h7770;
    d_mem_wdata       = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d_mem_byte_enable = 2'b10;
    d_mem_read        = 1'b1;
    d_mem_write       = 1'b1;
    tick();
    tests_run++;
    if (l2_mem_write !== 1'b1 || l2_mem_read !== 1'b0 || l2_mem_byte_enable !== 2'b10) begin
      tests_failed++;
      $display("FAIL rw_as_write: got wr=%b rd=%b be=%b exp 1 0 10", l2_mem_write, l2_mem_read, l2_mem_byte_enable);
    end
    l2_mem_resp = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    d_mem_address = 16'h3330;
    d_mem_read    = 1'b1;
    tick();
    tests_run++;
    if (l2_mem_read !== 1'b1 || l2_mem_address !== 16'h3330) begin
      tests_failed++;
      $display("FAIL rstmid_grant: got rd=%b addr=%h exp 1 3330", l2_mem_read, l2_mem_address);
    end
    l2_mem_resp = 1'b1;
    reset       = 1'b1;
    #1;
    tests_run++;
    if (l2_mem_read !== 1'b0 || l2_mem_write !== 1'b0 || l2_mem_address !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rstmid_abandon: got rd=%b wr=%b addr=%h exp 0 0 0000", l2_mem_read, l2_mem_write, l2_mem_address);
    end
    tests_run++;
    if (d_mem_resp !== 1'b0 || i_mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_resp: got d=%b i=%b exp 0 0", d_mem_resp, i_mem_resp);
    end
    d_mem_read = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (d_mem_resp !== 1'b0 || i_mem_resp !== 1'b0 || l2_mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_late_resp: got d=%b i=%b rd=%b exp 0 0 0", d_mem_resp, i_mem_resp, l2_mem_read);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_spurious_idle();
    l2_mem_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (i_mem_resp !== 1'b0 || d_mem_resp !== 1'b0 || l2_mem_read !== 1'b0 || l2_mem_write !== 1'b0) begin
        tests_failed++;
        $display("FAIL spurious_idle_%0d: got i=%b d=%b rd=%b wr=%b exp all 0", k, i_mem_resp, d_mem_resp, l2_mem_read, l2_mem_write);
      end
    end
    l2_mem_resp   = 1'b0;
    i_mem_address = 16'h5550;
    i_mem_read    = 1'b1;
    tick();
    tests_run++;
    if (l2_mem_read !== 1'b1 || l2_mem_address !== 16'h5550) begin
      tests_failed++;
      $display("FAIL spurious_then_grant: got rd=%b addr=%h exp 1 5550", l2_mem_read, l2_mem_address);
    end
    l2_mem_resp = 1'b1;
    #1;
    tests_run++;
    if (i_mem_resp !== 1'b1) begin
      tests_failed++;
      $display("FAIL spurious_then_resp: got %b exp 1", i_mem_resp);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_simultaneous();
    test_d_write();
    test_rr_no_preempt();
    test_read_write_both();
    test_reset_mid();
    test_spurious_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/l1_l2_arbiter.md
L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  async active-high reset.
REQ-004 i_mem_address  input  16 (lc3b_word)  I-cache miss line address.
REQ-005 i_mem_read  input  1  I-cache line read request, held until i_mem_resp.
REQ-006 i_mem_rdata  output  128 (lc3b_chunk)  line returned to I-cache.
REQ-007 i_mem_resp  output  1  one-cycle completion pulse to I-cache.
REQ-008 d_mem_address  input  16  D-cache line address.
REQ-009 d_mem_wdata  input  128  D-cache writeback line.
REQ-010 d_mem_read / d_mem_write  input  1 each  D-cache requests, held until d_mem_resp.
REQ-011 d_mem_byte_enable  input  2 (lc3b_mem_wmask)  D-cache write mask.
REQ-012 d_mem_rdata  output  128  line returned to D-cache.
REQ-013 d_mem_resp  output  1  one-cycle completion pulse to D-cache.
REQ-014 l2_mem_address  output  16; l2_mem_wdata  output  128; l2_mem_byte_enable  output  2: captured request to L2.
REQ-015 l2_mem_read / l2_mem_write  output  1 each  L2 request strobes.
REQ-016 l2_mem_rdata  input  128; l2_mem_resp  input  1: L2 completion.

Function
REQ-017 FSM states SHALL be IDLE, SERVE_I, SERVE_D; plus a last_grant bit (I or D).
REQ-018 In IDLE, the arbiter SHALL sample requests each edge; a request is i_mem_read, or d_mem_read|d_mem_write.
REQ-019 Single request pending: go to the matching SERVE state next edge.
REQ-020 Both pending: grant the requester not equal to last_grant (round-robin); last_grant updates at every grant.
REQ-021 On grant edge, the arbiter SHALL register address, wdata, byte_enable, read, write of the winner; I-cache grant registers wdata=0, byte_enable=2'b11, write=0.
REQ-022 D-cache with both read and write set SHALL be captured as write only.
REQ-023 l2_mem_read/l2_mem_write SHALL be the captured strobes ANDed with state!=IDLE; all other l2_* outputs are the capture registers.
REQ-024 Grant latency: request visible in IDLE at edge N -> L2 strobe asserted in cycle N+1.
REQ-025 i_mem_resp = l2_mem_resp & (state==SERVE_I); d_mem_resp = l2_mem_resp & (state==SERVE_D); combinational.
REQ-026 i_mem_rdata and d_mem_rdata SHALL both equal l2_mem_rdata continuously; valid only with respective resp.
REQ-027 On the edge where l2_mem_resp is high in a SERVE state, the FSM SHALL return to IDLE; strobes drop in the next cycle.
REQ-028 One IDLE cycle minimum between transactions; a requester still asserting in that IDLE cycle is treated as a new request.
REQ-029 l2_mem_resp in IDLE SHALL be ignored (no resp pulse, no state change).
REQ-030 Requests arriving during SERVE SHALL wait; no preemption, no queueing beyond the held request.
REQ-031 Throughput bound: no requester waits more than one other transaction once asserted.

Reset
REQ-032 Reset SHALL force state=IDLE, last_grant=I, capture registers=0, l2_mem_read=l2_mem_write=0, i_mem_resp=d_mem_resp=0, asynchronously.
REQ-033 Reset mid-transaction SHALL abandon it; a late l2_mem_resp after reset is ignored per REQ-029.

Structure
REQ-034 lc3b_word, lc3b_chunk, lc3b_mem_wmask SHALL come from lc3b_types; FSM state enum SHALL be local to the module.
REQ-035 Single flat module; no sub-modules; 120-250 lines RTL.

Verification
REQ-036 I-only read 0x1230 -> l2_mem_read=1, l2_mem_address=0x1230 next cycle; L2 resp with data D1 -> i_mem_resp one cycle, i_mem_rdata=D1, d_mem_resp=0.
REQ-037 Simultaneous I read 0x0100 and D read 0x0200 after reset -> D served first (last_grant=I), then I; two L2 transactions in that order.
REQ-038 D write 0x4440, wdata all 0xA5, mask 2'b01 -> l2_mem_write=1, matching address/wdata/mask; d_mem_resp on L2 resp; l2_mem_read=0 throughout.
REQ-039 D asserts read and write together -> captured as write only (l2_mem_read=0).
REQ-040 Reset asserted during SERVE_D before L2 resp -> strobes 0 immediately; subsequent stray l2_mem_resp produces no i/d resp.
REQ-041 Spurious l2_mem_resp in IDLE with no requests -> state stays IDLE, no resp outputs.
